// File: rtl/csa_wide_seq_if.sv
// csa_wide_seq_if -- bundle of the request/response handshake and the
// external chunk-adder connection for csa_wide_seq.
//
// Signals (named from the block's point of view):
//   i_valid / o_ready         request handshake
//   i_add_term1, i_add_term2  W-bit operands A and B (W = WIDTH*BEATS)
//   o_valid / i_ready         result handshake
//   o_sum, o_cout             W-bit result and final carry
//   o_add_a, o_add_b          WIDTH-bit chunk operands to the external adder
//   o_add_cin                 chunk carry-in to the external adder
//   i_add_sum, i_add_cout     combinational adder result for the same cycle
//   i_sub                     subtract select, only with CSA_WIDE_SEQ_SUB_EN
//
// Modports: slave is the block itself; master is the requester, result
// consumer and external adder taken together.
interface csa_wide_seq_if #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned BEATS = 4
);
  localparam int unsigned W = WIDTH * BEATS;

  logic             i_valid;
  logic             o_ready;
  logic [W-1:0]     i_add_term1;
  logic [W-1:0]     i_add_term2;
  logic             o_valid;
  logic             i_ready;
  logic [W-1:0]     o_sum;
  logic             o_cout;
  logic [WIDTH-1:0] o_add_a;
  logic [WIDTH-1:0] o_add_b;
  logic             o_add_cin;
  logic [WIDTH-1:0] i_add_sum;
  logic             i_add_cout;
`ifdef CSA_WIDE_SEQ_SUB_EN
  logic             i_sub;
`endif

  modport slave (
`ifdef CSA_WIDE_SEQ_SUB_EN
    input  i_sub,
`endif
    input  i_valid,
    output o_ready,
    input  i_add_term1,
    input  i_add_term2,
    output o_valid,
    input  i_ready,
    output o_sum,
    output o_cout,
    output o_add_a,
    output o_add_b,
    output o_add_cin,
    input  i_add_sum,
    input  i_add_cout
  );

  modport master (
`ifdef CSA_WIDE_SEQ_SUB_EN
    output i_sub,
`endif
    output i_valid,
    input  o_ready,
    output i_add_term1,
    output i_add_term2,
    input  o_valid,
    output i_ready,
    input  o_sum,
    input  o_cout,
    input  o_add_a,
    input  o_add_b,
    input  o_add_cin,
    output i_add_sum,
    output i_add_cout
  );

endinterface

// File: rtl/csa_wide_seq.sv
// csa_wide_seq -- W-bit adder (W = WIDTH*BEATS) built by streaming BEATS
// chunks of WIDTH bits through one external combinational WIDTH-bit adder,
// least-significant chunk first, rippling the carry through a register.
//
// Ports:
//   i_clk  sole clock, rising edge
//   i_rst  synchronous, active-high reset (wins over a simultaneous handshake)
//   bus    csa_wide_seq_if.slave: request handshake and operands, result
//          handshake with o_sum/o_cout, and the external adder connection
//          (o_add_a, o_add_b, o_add_cin out; i_add_sum, i_add_cout in).
//
// Timing: the accepting edge loads the operands; BEATS further edges each
// retire one chunk; the result is then held with o_valid=1 until i_ready.
// One request per BEATS+2 cycles at best (no acceptance straight from DONE).
//
// Optional feature: define CSA_WIDE_SEQ_SUB_EN to add bus.i_sub. With
// i_sub=1 at acceptance the block computes A-B mod 2^W by feeding ~B chunks
// and a carry-in of 1; o_cout=1 then means "no borrow".
module csa_wide_seq #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned BEATS = 4
) (
  input logic           i_clk,
  input logic           i_rst,
  csa_wide_seq_if.slave bus
);

  localparam int unsigned W    = WIDTH * BEATS;
  localparam int unsigned CntW = $clog2(BEATS);

  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] beat_q, beat_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
`ifdef CSA_WIDE_SEQ_SUB_EN
  logic            sub_q, sub_d;
`endif

  // Chunk of each operand addressed by the current beat.
  logic [WIDTH-1:0] a_chunk;
  logic [WIDTH-1:0] b_chunk;

  always_comb begin
    a_chunk = a_q[beat_q * WIDTH +: WIDTH];
    b_chunk = b_q[beat_q * WIDTH +: WIDTH];
`ifdef CSA_WIDE_SEQ_SUB_EN
    // Two's-complement subtract: A + ~B + 1, the +1 entering as the
    // initial carry loaded at acceptance.
    if (sub_q) begin
      b_chunk = ~b_chunk;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef CSA_WIDE_SEQ_SUB_EN
    sub_d   = sub_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.i_valid) begin
          a_d     = bus.i_add_term1;
          b_d     = bus.i_add_term2;
          beat_d  = '0;
`ifdef CSA_WIDE_SEQ_SUB_EN
          sub_d   = bus.i_sub;
          carry_d = bus.i_sub;
`else
          carry_d = 1'b0;
`endif
          state_d = StRun;
        end
      end

      StRun: begin
        // The external adder is combinational, so its result for this
        // beat's chunk is already present on i_add_sum/i_add_cout.
        sum_d[beat_q * WIDTH +: WIDTH] = bus.i_add_sum;
        carry_d = bus.i_add_cout;
        beat_d  = beat_q + 1'b1;
        if (beat_q == LastBeat) begin
          state_d = StDone;
        end
      end

      StDone: begin
        // Operands and i_valid are ignored here; a new request can only be
        // taken once back in StIdle.
        if (bus.i_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs. The adder operands are forced to zero outside StRun so the
  // external adder sees quiet inputs, and its results are then unused.
  always_comb begin
    bus.o_ready   = (state_q == StIdle);
    bus.o_valid   = (state_q == StDone);
    bus.o_sum     = sum_q;
    // In StDone the carry register holds the final i_add_cout.
    bus.o_cout    = carry_q;
    bus.o_add_a   = '0;
    bus.o_add_b   = '0;
    bus.o_add_cin = 1'b0;
    if (state_q == StRun) begin
      bus.o_add_a   = a_chunk;
      bus.o_add_b   = b_chunk;
      bus.o_add_cin = carry_q;
    end
  end

  // State registers. Reset aborts any operation in flight and wipes the
  // partial result so nothing stale is visible afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
`ifdef CSA_WIDE_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
`ifdef CSA_WIDE_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

endmodule

// File: tb/tb_csa_wide_seq.sv
// Self-checking bench for csa_wide_seq (WIDTH=22, BEATS=4). The bench plays
// requester, consumer and external chunk adder; expected results come from
// plain wide arithmetic on the full operands.
`timescale 1ns/1ps
module tb_csa_wide_seq;

  localparam int unsigned WIDTH = 22;
  localparam int unsigned BEATS = 4;
  localparam int unsigned W     = WIDTH * BEATS;

  typedef logic [W:0] wide_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  csa_wide_seq_if #(.WIDTH(WIDTH), .BEATS(BEATS)) bus ();

  csa_wide_seq #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External combinational chunk adder.
  logic [WIDTH:0] add_full;
  assign add_full = {1'b0, bus.o_add_a} + {1'b0, bus.o_add_b}
                  + {{WIDTH{1'b0}}, bus.o_add_cin};
  assign bus.i_add_sum  = add_full[WIDTH-1:0];
  assign bus.i_add_cout = add_full[WIDTH];

  task automatic check(input string tag, input wide_t obs, input wide_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic wide_t mask_n(input int unsigned n);
    wide_t one;
    one = 1;
    return (one << n) - 1;
  endfunction

  // Full result: bit W is the final carry (for subtraction: 1 = no borrow).
  function automatic wide_t ref_result(input wide_t a, input wide_t b, input bit sub);
    wide_t r;
    if (sub) begin
      r    = (a - b) & mask_n(W);
      r[W] = (a >= b);
    end else begin
      r = a + b;
    end
    return r;
  endfunction

  // Carry into bit k*WIDTH of the full-width operation.
  function automatic bit ref_cin(input wide_t a, input wide_t b, input bit sub,
                                 input int unsigned k);
    wide_t m;
    m = mask_n(k * WIDTH);
    if (sub) return ((a & m) >= (b & m));
    return (((a & m) + (b & m)) > m);
  endfunction

  function automatic wide_t ref_chunk(input wide_t x, input int unsigned k);
    return (x >> (k * WIDTH)) & mask_n(WIDTH);
  endfunction

  function automatic wide_t rand_wide();
    return wide_t'({$urandom(), $urandom(), $urandom()}) & mask_n(W);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input wide_t a, input wide_t b, input bit sub);
    bus.i_add_term1 = a[W-1:0];
    bus.i_add_term2 = b[W-1:0];
`ifdef CSA_WIDE_SEQ_SUB_EN
    bus.i_sub = sub;
`else
    if (sub) $display("[TB] subtract requested in an add-only build");
`endif
  endtask

  task automatic check_adder_quiet(input string tag);
    check({tag, ".add_a0"},  wide_t'(bus.o_add_a),   0);
    check({tag, ".add_b0"},  wide_t'(bus.o_add_b),   0);
    check({tag, ".add_ci0"}, wide_t'(bus.o_add_cin), 0);
  endtask

  // One full transaction from IDLE. junk=1 wiggles i_valid and the operands
  // while busy; ready_delay is the number of DONE cycles with i_ready low.
  task automatic run_op(input string tag, input wide_t a, input wide_t b, input bit sub,
                        input int ready_delay, input bit junk);
    wide_t exp;
    wide_t bx;
    int    edges;
    int    beat;
    exp = ref_result(a, b, sub);
    check({tag, ".idle_rdy"}, wide_t'(bus.o_ready), 1);
    check_adder_quiet({tag, ".idle"});
    drive_req(a, b, sub);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    edges = 1;
    beat  = 0;
    while (bus.o_valid !== 1'b1 && edges < 4 * BEATS) begin
      check({tag, ".run_rdy"}, wide_t'(bus.o_ready), 0);
      if (beat < BEATS) begin
        bx = sub ? (~b & mask_n(W)) : b;
        check($sformatf("%s.a%0d", tag, beat),   wide_t'(bus.o_add_a), ref_chunk(a, beat));
        check($sformatf("%s.b%0d", tag, beat),   wide_t'(bus.o_add_b), ref_chunk(bx, beat));
        check($sformatf("%s.cin%0d", tag, beat), wide_t'(bus.o_add_cin),
              wide_t'(ref_cin(a, b, sub, beat)));
      end
      beat++;
      if (junk) begin
        bus.i_valid = 1'($urandom_range(0, 1));
        drive_req(rand_wide(), rand_wide(), 1'($urandom_range(0, 1)) & sub);
      end
      tick();
      edges++;
    end
    bus.i_valid = 1'b0;
    check({tag, ".latency"}, wide_t'(edges), wide_t'(BEATS + 1));
    check({tag, ".sum"},  wide_t'(bus.o_sum),  exp & mask_n(W));
    check({tag, ".cout"}, wide_t'(bus.o_cout), wide_t'(exp[W]));
    check({tag, ".done_rdy"}, wide_t'(bus.o_ready), 0);
    check_adder_quiet({tag, ".done"});
    for (int i = 0; i < ready_delay; i++) begin
      bus.i_ready = 1'b0;
      if (junk) begin
        bus.i_valid = 1'b1;
        drive_req(rand_wide(), rand_wide(), 1'b0);
      end
      tick();
      check($sformatf("%s.hold_v%0d", tag, i), wide_t'(bus.o_valid), 1);
      check($sformatf("%s.hold_s%0d", tag, i), wide_t'(bus.o_sum),   exp & mask_n(W));
      check($sformatf("%s.hold_c%0d", tag, i), wide_t'(bus.o_cout),  wide_t'(exp[W]));
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    check({tag, ".ret_valid"}, wide_t'(bus.o_valid), 0);
    check({tag, ".ret_rdy"},   wide_t'(bus.o_ready), 1);
    tick();
    check({tag, ".no_extra"},  wide_t'(bus.o_valid), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    wide_t a;
    wide_t b;
    bit    s;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    drive_req(0, 0, 1'b0);
    tick();
    tick();
    check("rst.valid", wide_t'(bus.o_valid), 0);
    check("rst.sum",   wide_t'(bus.o_sum),   0);
    check("rst.cout",  wide_t'(bus.o_cout),  0);
    rst = 1'b0;
    tick();
    check("rst.ready", wide_t'(bus.o_ready), 1);
    check_adder_quiet("rst");

    // Carry rippling through every chunk boundary.
    run_op("allones", mask_n(W), 1, 1'b0, 0, 1'b0);
    // Fixed vector, no final carry.
    run_op("vec", 88'h123456789ABCDEF012345, 88'h0FEDCBA9876543210FEDC, 1'b0, 1, 1'b0);
    // Result held while the consumer stalls.
    run_op("hold", rand_wide(), rand_wide(), 1'b0, 3, 1'b0);
    // Activity on the request side while busy must be ignored.
    run_op("junk", rand_wide(), rand_wide(), 1'b0, 2, 1'b1);

    // Reset at beat 2 aborts the operation.
    drive_req(mask_n(W), mask_n(W), 1'b0);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.ready", wide_t'(bus.o_ready), 1);
    check("abort.valid", wide_t'(bus.o_valid), 0);
    check("abort.sum",   wide_t'(bus.o_sum),   0);
    check("abort.cout",  wide_t'(bus.o_cout),  0);
    repeat (BEATS + 2) tick();
    check("abort.no_result", wide_t'(bus.o_valid), 0);
    run_op("after_abort", rand_wide(), rand_wide(), 1'b0, 1, 1'b0);

    // Reset beats a simultaneous handshake.
    drive_req(rand_wide(), rand_wide(), 1'b0);
    bus.i_valid = 1'b1;
    rst         = 1'b1;
    tick();
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    check("prio.ready", wide_t'(bus.o_ready), 1);
    tick();
    check("prio.ready2", wide_t'(bus.o_ready), 1);

`ifdef CSA_WIDE_SEQ_SUB_EN
    run_op("sub_neg", 5, 7, 1'b1, 0, 1'b0);
    run_op("sub_pos", 7, 5, 1'b1, 1, 1'b0);
`endif

    for (int i = 0; i < 8; i++) begin
      a = rand_wide();
      b = (i == 3) ? a : rand_wide();
`ifdef CSA_WIDE_SEQ_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run_op($sformatf("rnd%0d", i), a, b, s, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
